seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 17 +
 rtl/hex_to_seg7.sv | 11 +
 rtl/seg_scan_driver.sv | 83 ++++++++
 tb/tb_seg_scan_driver.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the eight-digit seven-segment scan driver:
// active-low segment code table, blank/off patterns and digit count.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] ANS_OFF = 8'hFF;

  // Active-low {g..a} codes, entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment code lookup.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] code
);

  assign code = SEG_CODES[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed eight-digit hex display driver with frame-aligned updates.
// Optional leading-zero blanking is enabled by defining SEG_BLANK_LEADING_ZERO_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [7:0]  ans,
  output logic        frame
);

  localparam int CNT_W = 24;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  digit_idx_t       idx_reg;
  logic [31:0]      pending_reg;
  logic [31:0]      display_reg;
  logic             tick;
  logic             wrap;
  logic [3:0]       nibble;
  logic [6:0]       code;
  logic             show;

  assign tick   = (cnt_reg == CNT_MAX);
  assign wrap   = tick && (idx_reg == digit_idx_t'(NUM_DIGITS - 1));
  assign nibble = display_reg[{idx_reg, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .code   (code)
  );

`ifdef SEG_BLANK_LEADING_ZERO_EN
  logic [NUM_DIGITS-1:0] nz;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nz
      assign nz[gi] = |display_reg[4*gi +: 4];
    end
  endgenerate

  // A digit is visible if it is digit 0 or any nibble at or above it is nonzero.
  assign show = (idx_reg == '0) || (|(nz >> idx_reg));
`else
  assign show = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      idx_reg     <= '0;
      pending_reg <= '0;
      display_reg <= '0;
      frame       <= 1'b0;
      ans         <= ANS_OFF;
      seg         <= SEG_BLANK;
    end else begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
      if (tick)
        idx_reg <= idx_reg + 1'b1;
      if (load)
        pending_reg <= data_in;
      // Display only changes at the frame boundary; a coincident load bypasses pending.
      if (wrap)
        display_reg <= load ? data_in : pending_reg;
      frame <= wrap;
      if (show) begin
        ans <= ~(8'h01 << idx_reg);
        seg <= code;
      end else begin
        ans <= ANS_OFF;
        seg <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (REFRESH_DIV 4 and 1) checked every cycle
// against a cycle-count based model, plus directed literal expectations.
module tb_seg_scan_driver;

`ifdef SEG_BLANK_LEADING_ZERO_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] data_in;
  logic [6:0]  seg4, seg1;
  logic [7:0]  ans4, ans1;
  logic        frame4, frame1;

  always #5 clk = ~clk;

  seg_scan_driver #(.REFRESH_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load),
    .seg(seg4), .ans(ans4), .frame(frame4)
  );

  seg_scan_driver #(.REFRESH_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load),
    .seg(seg1), .ans(ans1), .frame(frame1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic bit shown(input logic [31:0] v, input int k);
    bit any_above = 1'b0;
    for (int j = k; j < 8; j++)
      if (v[4*j +: 4] != 4'h0) any_above = 1'b1;
    return !BLANK_EN || (k == 0) || any_above;
  endfunction

  // Model: t counts non-reset edges; slot and wrap follow directly from t and the divider.
  int          t_m [2];
  logic [31:0] pend_m [2];
  logic [31:0] disp_m [2];
  logic [7:0]  exp_ans [2];
  logic [6:0]  exp_seg [2];
  logic        exp_frame [2];
  bit          model_valid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int d;
      int slot;
      bit wrp;
      if (reset) begin
        t_m[i] = 0;
        pend_m[i] = '0;
        disp_m[i] = '0;
        exp_ans[i] = 8'hFF;
        exp_seg[i] = 7'h7F;
        exp_frame[i] = 1'b0;
      end else begin
        d = (i == 0) ? 4 : 1;
        slot = (t_m[i] / d) % 8;
        wrp = (t_m[i] % (8 * d)) == (8 * d - 1);
        if (shown(disp_m[i], slot)) begin
          exp_ans[i] = ~(8'h01 << slot);
          exp_seg[i] = seg_code(disp_m[i][4*slot +: 4]);
        end else begin
          exp_ans[i] = 8'hFF;
          exp_seg[i] = 7'h7F;
        end
        exp_frame[i] = wrp;
        if (wrp) disp_m[i] = load ? data_in : pend_m[i];
        if (load) pend_m[i] = data_in;
        t_m[i]++;
      end
    end
    model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("m_ans4", ans4, exp_ans[0]);
      chk("m_seg4", seg4, exp_seg[0]);
      chk("m_frame4", frame4, exp_frame[0]);
      chk("m_ans1", ans1, exp_ans[1]);
      chk("m_seg1", seg1, exp_seg[1]);
      chk("m_frame1", frame1, exp_frame[1]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    load = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ans", ans4, 8'hFF);
    chk("rst_seg", seg4, 7'h7F);
    chk("rst_frame", frame4, 1'b0);
    $display("TXN reset held 3 cycles");

    // Load right after reset; shows only from the next frame.
    reset = 1'b0; load = 1'b1; data_in = 32'h89ABCDEF;
    @(negedge clk);
    load = 1'b0;
    chk("post_rst_ans", ans4, 8'hFE);
    chk("post_rst_seg", seg4, 7'h40);
    repeat (31) @(negedge clk);
    chk("wrap1_frame", frame4, 1'b1);
    chk("wrap1_ans", ans4, 8'h7F);
    chk("old_frame_seg", seg4, 7'h40);
    @(negedge clk);
    chk("new_d0_seg", seg4, 7'b0001110);
    chk("new_d0_ans", ans4, 8'hFE);
    chk("frame_low", frame4, 1'b0);
    repeat (28) @(negedge clk);
    chk("new_d7_ans", ans4, 8'h7F);
    chk("new_d7_seg", seg4, 7'b0000000);
    $display("TXN load 89ABCDEF shown next frame");

    // Load in the exact wrap-tick cycle.
    repeat (2) @(negedge clk);
    load = 1'b1; data_in = 32'h00000005;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("bypass_d0_seg", seg4, 7'b0010010);
    chk("bypass_d0_ans", ans4, 8'hFE);
    repeat (4) @(negedge clk);
    chk("bypass_d1_ans", ans4, BLANK_EN ? 8'hFF : 8'hFD);
    chk("bypass_d1_seg", seg4, BLANK_EN ? 7'h7F : 7'h40);
    $display("TXN bypass load 00000005 at wrap tick");

    // Two loads in one frame; last wins, current frame untouched.
    @(negedge clk);
    load = 1'b1; data_in = 32'h11111111;
    @(negedge clk);
    load = 1'b0;
    repeat (9) @(negedge clk);
    load = 1'b1; data_in = 32'h22222222;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    chk("cur_d5_ans", ans4, BLANK_EN ? 8'hFF : 8'hDF);
    chk("cur_d5_seg", seg4, BLANK_EN ? 7'h7F : 7'h40);
    repeat (12) @(negedge clk);
    chk("last_load_seg", seg4, 7'b0100100);
    chk("last_load_ans", ans4, 8'hFE);
    $display("TXN double load 11111111 then 22222222");

    // Reset with load at idx 5.
    repeat (20) @(negedge clk);
    reset = 1'b1; load = 1'b1; data_in = 32'hFFFFFFFF;
    @(negedge clk);
    chk("mid_rst_ans", ans4, 8'hFF);
    chk("mid_rst_seg", seg4, 7'h7F);
    chk("mid_rst_frame", frame4, 1'b0);
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    @(negedge clk);
    chk("mid_rel_ans", ans4, 8'hFE);
    chk("mid_rel_seg", seg4, 7'h40);
    repeat (32) @(negedge clk);
    chk("discard_seg", seg4, 7'h40);
    chk("discard_ans", ans4, 8'hFE);
    $display("TXN reset mid-frame with load discarded");

    // REFRESH_DIV=1 instance with value 00000120.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; load = 1'b1; data_in = 32'h00000120;
    @(negedge clk);
    load = 1'b0;
    repeat (6) @(negedge clk);
    chk("d1_frame_e7", frame1, 1'b0);
    @(negedge clk);
    chk("d1_frame_e8", frame1, 1'b1);
    @(negedge clk);
    chk("d1_d0_ans", ans1, 8'hFE);
    chk("d1_d0_seg", seg1, 7'h40);
    @(negedge clk);
    chk("d1_d1_ans", ans1, 8'hFD);
    chk("d1_d1_seg", seg1, 7'b0100100);
    @(negedge clk);
    chk("d1_d2_ans", ans1, 8'hFB);
    chk("d1_d2_seg", seg1, 7'b1111001);
    @(negedge clk);
    chk("d1_d3_ans", ans1, BLANK_EN ? 8'hFF : 8'hF7);
    chk("d1_d3_seg", seg1, BLANK_EN ? 7'h7F : 7'h40);
    repeat (4) @(negedge clk);
    chk("d1_frame_e16", frame1, 1'b1);
    $display("TXN div1 load 00000120 frame period 8");

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
